io_port_bank: RTL and testbench
===============================

Name: io_port_bank

Overview:
- Responder at the far end of the MMU I/O port (0x80000000–0x800000FF).
- Accepts the registered io_addr/io_en/io_we/io_data_write strobes and returns io_data_read in the same cycle.
- Hosts a GPIO output/input register pair, a buffered 8N1 UART transmitter, and a 64-bit free-running cycle counter with snapshot read.

Parameters:
GPIO_W, 8, width of gpio_out and gpio_in (1..32)
CLKS_PER_BIT, 104, clocks per UART bit (>=2)
FIFO_DEPTH_LOG, 2, log2 of TX FIFO depth (depth 4)

Ports:
clk  input  1  system clock, rising edge
resetb  input  1  asynchronous active-low reset
io_addr  input  8  byte offset within I/O window
io_en  input  1  access strobe, one cycle per access
io_we  input  1  1=write, 0=read (valid with io_en)
io_data_write  input  32  write data (lane-shifted by MMU)
io_data_read  output  32  read data, combinational from io_addr/state
gpio_in  input  GPIO_W  asynchronous external inputs
gpio_out  output  GPIO_W  registered outputs
uart_tx  output  1  serial line, idle high

Behaviour:
- Reset is asynchronous and active-low on resetb. Values in reset:
  - gpio_out=0, uart_tx=1, FIFO empty, overflow=0.
  - TX FSM in IDLE; cycle counter=0; hi snapshot=0; gpio_in sync flops=0.
- Decode uses io_addr[7:2]; io_addr[1:0] is ignored. Registers use bit 0 upward of io_data_write. Software uses SW/LW.
- Reads:
  - io_data_read is valid combinationally while io_en=1 and io_we=0. The MMU samples it in that cycle.
  - io_data_read=0 when io_en=0, and for unmapped offsets.
  - Unused bits read 0.
- Writes take effect at the rising edge that ends the cycle with io_en=1 and io_we=1. Writes to unmapped or RO offsets are ignored.
- Register map:
  - 0x00 GPIO_OUT, RW: [GPIO_W-1:0].
  - 0x04 GPIO_IN, RO: gpio_in through a 2-flop synchronizer. Latency from a pin change to a readable value is 2 edges.
  - 0x08 TX_DATA, W: pushes io_data_write[7:0] into the FIFO. Reads 0.
  - 0x0C TX_STATUS, RW1C. Fields:
    - bit0 full, bit1 empty, bit2 busy (FSM not IDLE).
    - bit3 overflow (sticky). Writing 1 to bit3 clears it; other bits are RO.
    - bits[8+:FIFO_DEPTH_LOG+1] FIFO count.
  - 0x10 CYCLE_LO, RO: counter[31:0]. A read access (io_en & !io_we) latches counter[63:32] into the hi snapshot at the same edge.
  - 0x14 CYCLE_HI, RO: the hi snapshot.
- Cycle counter:
  - Increments by 1 every clock and wraps 2^64-1 -> 0.
  - The LO value returned is the pre-edge value, consistent with the snapshot.
- TX FIFO:
  - Circular buffer with wrap-around pointers and count 0..2^FIFO_DEPTH_LOG.
  - full/empty are evaluated on pre-edge count.
  - A push while full is dropped and sets overflow, even if a pop happens at the same edge.
  - Push and pop at the same edge (not full, not empty): count unchanged, both pointers advance.
  - Push while empty and FSM IDLE: the byte is written; the pop happens on the next cycle.
- TX FSM (bit timer counts CLKS_PER_BIT-1 down to 0):
  - IDLE: uart_tx=1. If the FIFO is not empty, pop the byte into a shift register and go to START.
  - START: uart_tx=0 for CLKS_PER_BIT clocks, then DATA.
  - DATA: uart_tx=shift[0], LSB first. After each bit period, shift right. After 8 bits go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT clocks, then IDLE.
  - Back-to-back bytes: IDLE lasts exactly 1 cycle between the STOP of one byte and the START of the next.
  - Frame length is 10*CLKS_PER_BIT clocks, plus 1 IDLE cycle.
- Reset mid-frame: uart_tx returns to 1 immediately (asynchronously), FIFO contents are discarded, and the counter clears.

Test Plan:
- Reset, then LW 0x0C -> 0x00000002; uart_tx=1; gpio_out=0; LW 0x04 with gpio_in=0xA5 held 2 edges -> 0x000000A5.
- SW 0x00 data 0x1234_5F3C (GPIO_W=8) -> gpio_out=0x3C at next edge; LW 0x00 -> 0x0000003C; SW 0x40 -> no state change, LW 0x40 -> 0.
- CLKS_PER_BIT=4: SW 0x08 data 0x55 -> uart_tx shows start 0, then bits 1,0,1,0,1,0,1,0, then stop 1, each exactly 4 clocks; busy=1 during the frame; status returns to 0x2 after STOP+IDLE.
- CLKS_PER_BIT=4, depth 4: 6 back-to-back SW 0x08 (0x01..0x06) -> first popped immediately, 4 buffered, 6th dropped. Status reads full=1, overflow=1, count=4. Line emits 0x01..0x05 with a 1-clock gap. SW 0x0C data 0x8 clears overflow.
- Preload counter near wrap by running from reset for 2^32+3 cycles (or force internal) -> LW 0x10 returns LO; a later LW 0x14 returns 0x00000001 even though the counter keeps running; the 2^64-1 -> 0 wrap is checked via force.
- Assert resetb low mid-DATA bit -> uart_tx=1 in the same cycle without a clock; after release, status=0x2 and no residual frame is emitted.

Source files
------------

// File: rtl/io_port_bank.sv
// io_port_bank
//   Responder behind the MMU I/O window (0x80000000-0x800000FF). It decodes
//   word offsets from io_addr[7:2] and answers reads combinationally in the
//   same cycle as the access strobe. It hosts:
//     - a GPIO output register and a 2-flop-synchronized GPIO input,
//     - an 8N1 UART transmitter fed by a small circular TX FIFO,
//     - a 64-bit free-running cycle counter whose high half is snapshotted
//       whenever the low half is read.
//
// Ports
//   clk            system clock, rising edge
//   resetb         asynchronous active-low reset
//   io_addr        byte offset within the I/O window (bits [1:0] ignored)
//   io_en          access strobe, one cycle per access
//   io_we          1 = write, 0 = read (qualified by io_en)
//   io_data_write  write data, registers use bit 0 upward
//   io_data_read   read data, combinational, 0 when idle or unmapped
//   gpio_in        asynchronous external inputs
//   gpio_out       registered GPIO outputs
//   uart_tx        serial line, idle high

module io_port_bank #(
  parameter int GPIO_W         = 8,
  parameter int CLKS_PER_BIT   = 104,
  parameter int FIFO_DEPTH_LOG = 2
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic [7:0]          io_addr,
  input  logic                io_en,
  input  logic                io_we,
  input  logic [31:0]         io_data_write,
  output logic [31:0]         io_data_read,
  input  logic [GPIO_W-1:0]   gpio_in,
  output logic [GPIO_W-1:0]   gpio_out,
  output logic                uart_tx
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
  localparam int CNT_W = FIFO_DEPTH_LOG + 1;
  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  // Address decode
  logic [5:0] word;
  logic       rd_acc;
  logic       wr_acc;
  logic       sel_gpio_out;
  logic       sel_gpio_in;
  logic       sel_tx_data;
  logic       sel_tx_status;
  logic       sel_cycle_lo;
  logic       sel_cycle_hi;

  assign word          = io_addr[7:2];
  assign rd_acc        = io_en & ~io_we;
  assign wr_acc        = io_en & io_we;
  assign sel_gpio_out  = (word == 6'h00);
  assign sel_gpio_in   = (word == 6'h01);
  assign sel_tx_data   = (word == 6'h02);
  assign sel_tx_status = (word == 6'h03);
  assign sel_cycle_lo  = (word == 6'h04);
  assign sel_cycle_hi  = (word == 6'h05);

  // Byte-lane bits and the upper write bits are not used by any register.
  logic unused_bits;
  assign unused_bits = ^{io_addr[1:0], io_data_write};

  // GPIO output register and input synchronizer
  logic [GPIO_W-1:0] gpio_meta_p0;
  logic [GPIO_W-1:0] gpio_sync_p1;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      gpio_out     <= '0;
      gpio_meta_p0 <= '0;
      gpio_sync_p1 <= '0;
    end else begin
      gpio_meta_p0 <= gpio_in;
      gpio_sync_p1 <= gpio_meta_p0;
      if (wr_acc && sel_gpio_out) begin
        gpio_out <= io_data_write[GPIO_W-1:0];
      end
    end
  end

  // Cycle counter with high-half snapshot taken on every LO read
  logic [63:0] cyc_cnt;
  logic [31:0] cyc_hi_snap;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cyc_cnt     <= '0;
      cyc_hi_snap <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 64'd1;
      if (rd_acc && sel_cycle_lo) begin
        cyc_hi_snap <= cyc_cnt[63:32];
      end
    end
  end

  // TX FIFO
  logic [7:0]                fifo_mem [DEPTH];
  logic [FIFO_DEPTH_LOG-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG-1:0] rd_ptr;
  logic [CNT_W-1:0]          fifo_cnt;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      push_req;
  logic                      push;
  logic                      pop;
  logic                      overflow;
  tx_state_t                 tx_state;

  assign fifo_full  = (fifo_cnt == DEPTH_C);
  assign fifo_empty = (fifo_cnt == '0);
  assign push_req   = wr_acc & sel_tx_data;
  // A push into a full FIFO is dropped even if the FSM pops at the same edge.
  assign push       = push_req & ~fifo_full;
  assign pop        = (tx_state == S_IDLE) & ~fifo_empty;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (wr_acc && sel_tx_status && io_data_write[3]) overflow <= 1'b0;
      if (push_req && fifo_full)                       overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= io_data_write[7:0];
  end

  // UART transmit FSM; uart_tx is registered and forced high by reset
  logic [TMR_W-1:0] bit_tmr;
  logic [2:0]       bit_idx;
  logic [7:0]       tx_shift;
  logic             tx_q;
  logic             bit_end;

  assign bit_end = (bit_tmr == '0);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      tx_state <= S_IDLE;
      bit_tmr  <= '0;
      bit_idx  <= '0;
      tx_q     <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (!fifo_empty) begin
            tx_state <= S_START;
            bit_tmr  <= TMR_MAX;
            tx_q     <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            tx_state <= S_DATA;
            bit_tmr  <= TMR_MAX;
            bit_idx  <= '0;
            tx_q     <= tx_shift[0];
          end else begin
            bit_tmr <= bit_tmr - 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            bit_tmr <= TMR_MAX;
            if (bit_idx == 3'd7) begin
              tx_state <= S_STOP;
              tx_q     <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              // shift[1] becomes shift[0] at this same edge
              tx_q    <= tx_shift[1];
            end
          end else begin
            bit_tmr <= bit_tmr - 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            tx_state <= S_IDLE;
            tx_q     <= 1'b1;
          end else begin
            bit_tmr <= bit_tmr - 1'b1;
          end
        end
        default: begin
          tx_state <= S_IDLE;
          tx_q     <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      tx_shift <= fifo_mem[rd_ptr];
    end else if (tx_state == S_DATA && bit_end) begin
      tx_shift <= {1'b0, tx_shift[7:1]};
    end
  end

  assign uart_tx = tx_q;

  // Read mux
  logic [31:0] status;
  logic [31:0] rdata;

  always_comb begin
    status              = '0;
    status[0]           = fifo_full;
    status[1]           = fifo_empty;
    status[2]           = (tx_state != S_IDLE);
    status[3]           = overflow;
    status[8 +: CNT_W]  = fifo_cnt;
  end

  always_comb begin
    rdata = '0;
    if (rd_acc) begin
      if (sel_gpio_out)       rdata[GPIO_W-1:0] = gpio_out;
      else if (sel_gpio_in)   rdata[GPIO_W-1:0] = gpio_sync_p1;
      else if (sel_tx_status) rdata = status;
      else if (sel_cycle_lo)  rdata = cyc_cnt[31:0];
      else if (sel_cycle_hi)  rdata = cyc_hi_snap;
      else                    rdata = '0;
    end
  end

  assign io_data_read = rdata;

endmodule

// File: tb/tb_io_port_bank.sv
module tb_io_port_bank;

  localparam int GPIO_W = 8;
  localparam int CPB    = 4;
  localparam int FDL    = 2;

  logic              clk;
  logic              resetb;
  logic [7:0]        io_addr;
  logic              io_en;
  logic              io_we;
  logic [31:0]       io_data_write;
  logic [31:0]       io_data_read;
  logic [GPIO_W-1:0] gpio_in;
  logic [GPIO_W-1:0] gpio_out;
  logic              uart_tx;

  io_port_bank #(
    .GPIO_W(GPIO_W),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH_LOG(FDL)
  ) dut (
    .clk(clk),
    .resetb(resetb),
    .io_addr(io_addr),
    .io_en(io_en),
    .io_we(io_we),
    .io_data_write(io_data_write),
    .io_data_read(io_data_read),
    .gpio_in(gpio_in),
    .gpio_out(gpio_out),
    .uart_tx(uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] sb_q[$];   // expected register read values
  logic        exp_tx[$]; // expected uart_tx level, one entry per clock

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1);
  end

  task automatic lw(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    io_addr = a; io_we = 1'b0; io_en = 1'b1;
    #1 d = io_data_read;
    @(posedge clk);
    #1 io_en = 1'b0;
  endtask

  task automatic sw(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    io_addr = a; io_data_write = d; io_we = 1'b1; io_en = 1'b1;
    @(posedge clk);
    #1 io_en = 1'b0; io_we = 1'b0;
  endtask

  // Expected line levels for one 8N1 frame plus the idle cycle after it.
  task automatic push_frame(input logic [7:0] b);
    for (int k = 0; k < CPB; k++) exp_tx.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < CPB; k++) exp_tx.push_back(b[i]);
    for (int k = 0; k < CPB; k++) exp_tx.push_back(1'b1);
    exp_tx.push_back(1'b1);
  endtask

  task automatic wait_start(input string nm, output bit ok);
    int t;
    t = 0;
    while (uart_tx !== 1'b0 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    ok = (uart_tx === 1'b0);
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: start bit not seen, got uart_tx=%b want 0 within 50 clocks", nm, uart_tx);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd, ex;
    resetb = 1'b0; io_en = 1'b0; io_we = 1'b0; io_addr = '0;
    io_data_write = '0; gpio_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) resetb = 1'b1;
    #1;
    n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL reset_uart_tx: got %b want 1", uart_tx); end
    n_cmp++; if (gpio_out !== 8'h00) begin n_bad++; $display("FAIL reset_gpio_out: got %h want 00", gpio_out); end
    n_cmp++; if (io_data_read !== 32'h0) begin n_bad++; $display("FAIL idle_read_zero: got %h want 0", io_data_read); end
    sb_q.push_back(32'h0000_0002);
    lw(8'h0C, rd); ex = sb_q.pop_front();
    n_cmp++; if (rd !== ex) begin n_bad++; $display("FAIL reset_status: got %h want %h", rd, ex); end
    @(negedge clk) gpio_in = 8'hA5;
    sb_q.push_back(32'h0000_0000);
    lw(8'h04, rd); ex = sb_q.pop_front();
    n_cmp++; if (rd !== ex) begin n_bad++; $display("FAIL gpio_in_1edge: got %h want %h", rd, ex); end
    sb_q.push_back(32'h0000_00A5);
    lw(8'h04, rd); ex = sb_q.pop_front();
    n_cmp++; if (rd !== ex) begin n_bad++; $display("FAIL gpio_in_2edge: got %h want %h", rd, ex); end
  endtask

  task automatic test_gpio();
    logic [31:0] rd, ex;
    sw(8'h00, 32'h1234_5F3C);
    n_cmp++; if (gpio_out !== 8'h3C) begin n_bad++; $display("FAIL gpio_out_write: got %h want 3c", gpio_out); end
    sb_q.push_back(32'h0000_003C);
    lw(8'h00, rd); ex = sb_q.pop_front();
    n_cmp++; if (rd !== ex) begin n_bad++; $display("FAIL gpio_out_read: got %h want %h", rd, ex); end
    sb_q.push_back(32'h0000_003C);
    lw(8'h03, rd); ex = sb_q.pop_front();
    n_cmp++; if (rd !== ex) begin n_bad++; $display("FAIL byte_offset_ignored: got %h want %h", rd, ex); end
    sw(8'h40, 32'hFFFF_FFFF);
    sw(8'h04, 32'h0000_00FF);
    sb_q.push_back(32'h0);
    lw(8'h40, rd); ex = sb_q.pop_front();
    n_cmp++; if (rd !== ex) begin n_bad++; $display("FAIL unmapped_read: got %h want %h", rd, ex); end
    sb_q.push_back(32'h0000_003C);
    lw(8'h00, rd); ex = sb_q.pop_front();
    n_cmp++; if (rd !== ex) begin n_bad++; $display("FAIL gpio_after_unmapped: got %h want %h", rd, ex); end
    sb_q.push_back(32'h0000_00A5);
    lw(8'h04, rd); ex = sb_q.pop_front();
    n_cmp++; if (rd !== ex) begin n_bad++; $display("FAIL gpio_in_ro: got %h want %h", rd, ex); end
    sb_q.push_back(32'h0);
    lw(8'h08, rd); ex = sb_q.pop_front();
    n_cmp++; if (rd !== ex) begin n_bad++; $display("FAIL tx_data_reads_zero: got %h want %h", rd, ex); end
  endtask

  task automatic test_uart_frame();
    logic b;
    push_frame(8'h55);
    sw(8'h08, 32'h0000_0055);
    // hold a status read for the whole frame; reads have no side effects
    io_addr = 8'h0C; io_we = 1'b0; io_en = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10 * CPB + 1; i++) begin
      b = exp_tx.pop_front();
      n_cmp++;
      if (uart_tx !== b) begin n_bad++; $display("FAIL frame55_bit clk%0d: got %b want %b", i, uart_tx, b); end
      n_cmp++;
      if (i < 10 * CPB) begin
        if (io_data_read[2] !== 1'b1) begin n_bad++; $display("FAIL frame55_busy clk%0d: got %b want 1", i, io_data_read[2]); end
      end else begin
        if (io_data_read !== 32'h2) begin n_bad++; $display("FAIL frame55_status_end: got %h want 2", io_data_read); end
      end
      @(posedge clk); #1;
    end
    io_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, ex;
    for (int k = 1; k <= 5; k++) push_frame(8'(k));
    for (int k = 0; k < 40; k++) exp_tx.push_back(1'b1);
    fork
      begin
        for (int k = 1; k <= 6; k++) sw(8'h08, 32'(k));
        sb_q.push_back(32'h0000_040D);
        lw(8'h0C, rd); ex = sb_q.pop_front();
        n_cmp++; if (rd !== ex) begin n_bad++; $display("FAIL b2b_full_ovf: got %h want %h", rd, ex); end
        sw(8'h0C, 32'h0000_0008);
        sb_q.push_back(32'h0000_0405);
        lw(8'h0C, rd); ex = sb_q.pop_front();
        n_cmp++; if (rd !== ex) begin n_bad++; $display("FAIL b2b_ovf_clear: got %h want %h", rd, ex); end
      end
      begin
        bit ok;
        logic b;
        int errs;
        wait_start("b2b_start", ok);
        errs = 0;
        if (ok) begin
          while (exp_tx.size() > 0) begin
            b = exp_tx.pop_front();
            n_cmp++;
            if (uart_tx !== b) begin
              n_bad++;
              if (errs < 8) $display("FAIL b2b_line remaining%0d: got %b want %b", exp_tx.size(), uart_tx, b);
              errs++;
            end
            @(posedge clk); #1;
          end
        end else begin
          exp_tx.delete();
        end
      end
    join
    sb_q.push_back(32'h0000_0002);
    lw(8'h0C, rd); ex = sb_q.pop_front();
    n_cmp++; if (rd !== ex) begin n_bad++; $display("FAIL b2b_final_status: got %h want %h", rd, ex); end
  endtask

  task automatic test_cycle();
    logic [31:0] rd, ex;
    @(negedge clk);
    force dut.cyc_cnt = 64'h0000_0000_FFFF_FFFE;
    #1 release dut.cyc_cnt;
    repeat (3) @(posedge clk);
    sb_q.push_back(32'h0000_0001);
    lw(8'h10, rd); ex = sb_q.pop_front();
    n_cmp++; if (rd !== ex) begin n_bad++; $display("FAIL cycle_lo: got %h want %h", rd, ex); end
    repeat (5) @(posedge clk);
    sb_q.push_back(32'h0000_0001);
    lw(8'h14, rd); ex = sb_q.pop_front();
    n_cmp++; if (rd !== ex) begin n_bad++; $display("FAIL cycle_hi_snap: got %h want %h", rd, ex); end
    @(negedge clk);
    force dut.cyc_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
    #1 release dut.cyc_cnt;
    sb_q.push_back(32'hFFFF_FFFF);
    lw(8'h10, rd); ex = sb_q.pop_front();
    n_cmp++; if (rd !== ex) begin n_bad++; $display("FAIL wrap_lo_max: got %h want %h", rd, ex); end
    sb_q.push_back(32'hFFFF_FFFF);
    lw(8'h14, rd); ex = sb_q.pop_front();
    n_cmp++; if (rd !== ex) begin n_bad++; $display("FAIL wrap_hi_max: got %h want %h", rd, ex); end
    sb_q.push_back(32'h0000_0001);
    lw(8'h10, rd); ex = sb_q.pop_front();
    n_cmp++; if (rd !== ex) begin n_bad++; $display("FAIL wrap_lo_after: got %h want %h", rd, ex); end
    sb_q.push_back(32'h0000_0000);
    lw(8'h14, rd); ex = sb_q.pop_front();
    n_cmp++; if (rd !== ex) begin n_bad++; $display("FAIL wrap_hi_after: got %h want %h", rd, ex); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rd, ex;
    bit ok;
    int errs;
    sw(8'h08, 32'h0000_00AA);
    sw(8'h08, 32'h0000_0033);
    wait_start("rst_start", ok);
    if (ok) begin
      repeat (13) @(posedge clk);
      #3;
      n_cmp++; if (uart_tx !== 1'b0) begin n_bad++; $display("FAIL rst_pre_data_bit: got %b want 0", uart_tx); end
      resetb = 1'b0;
      #1;
      n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL rst_async_tx: got %b want 1", uart_tx); end
      n_cmp++; if (gpio_out !== 8'h00) begin n_bad++; $display("FAIL rst_gpio_out: got %h want 00", gpio_out); end
      @(negedge clk) resetb = 1'b1;
      sb_q.push_back(32'h0000_0001);
      lw(8'h10, rd); ex = sb_q.pop_front();
      n_cmp++; if (rd !== ex) begin n_bad++; $display("FAIL rst_counter_clear: got %h want %h", rd, ex); end
      sb_q.push_back(32'h0000_0002);
      lw(8'h0C, rd); ex = sb_q.pop_front();
      n_cmp++; if (rd !== ex) begin n_bad++; $display("FAIL rst_status: got %h want %h", rd, ex); end
      errs = 0;
      for (int i = 0; i < 60; i++) begin
        @(posedge clk); #1;
        if (uart_tx !== 1'b1) errs++;
      end
      n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL rst_no_residual: got %0d low clocks want 0", errs); end
    end
  endtask

  initial begin
    test_reset();
    test_gpio();
    test_uart_frame();
    test_back_to_back();
    test_cycle();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
